// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared constants and IF/ID record for the Mips31 fetch stage
//
// Purpose: memory-map constants, NOP encoding and the packed IF/ID record
// used by ifetch and if_id_reg.
package mips_pkg;

  localparam logic [31:0] TEXT_BASE  = 32'h0040_0000;
  localparam logic [31:0] EXC_VECTOR = 32'h0040_0004;
  localparam int          IMEM_AW    = 11;
  localparam logic [31:0] NOP        = 32'h0000_0000;

  // Size of the text window in bytes; offsets at or above this fault.
  localparam logic [31:0] TEXT_BYTES = 32'd4 << IMEM_AW;

  typedef struct packed {
    logic        valid;
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc4;
    logic        fault;
  } if_id_t;

endpackage

// File: rtl/if_id_reg.sv
// rtl/if_id_reg.sv - IF/ID pipeline register with hold, bubble and load
//
// Purpose: holds the fetched instruction record between IF and ID.
// Ports:
//   clk      in  : rising-edge clock
//   rst_n    in  : synchronous active-low reset, clears every field
//   i_bubble in  : load a bubble (valid/instr/fault cleared, pc/pc4 from i_load)
//   i_hold   in  : keep the current contents
//   i_load   in  : record captured on a normal advance
//   o_q      out : registered record
module if_id_reg
  import mips_pkg::*;
(
  input  logic   clk,
  input  logic   rst_n,
  input  logic   i_bubble,
  input  logic   i_hold,
  input  if_id_t i_load,
  output if_id_t o_q
);

  if_id_t r_q;

  // Bubble beats hold so that a flush during a stall still squashes IF/ID.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_q <= '0;
    end else if (i_bubble) begin
      r_q <= '{valid: 1'b0, instr: NOP, pc: i_load.pc, pc4: i_load.pc4, fault: 1'b0};
    end else if (!i_hold) begin
      r_q <= i_load;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/ifetch.sv
// rtl/ifetch.sv - Mips31 instruction-fetch stage (PC, next-PC mux, IF/ID)
//
// Purpose: holds the PC, addresses instruction memory, flags bad fetches and
// captures the returned word into IF/ID.
// Ports:
//   clk, rst_n            : clock, synchronous active-low reset
//   stall                 : hold PC and IF/ID
//   flush                 : bubble into IF/ID
//   redirect_valid/_pc    : branch/jump target from ID (ignored while stalled)
//   exc_valid/exc_pc      : exception or eret entry, overrides stall
//   imem_addr             : word address into imem, combinational from PC
//   imem_rd               : instruction word returned in the same cycle
//   pc                    : current fetch PC
//   if_id_*               : IF/ID register outputs
module ifetch
  import mips_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               stall,
  input  logic               flush,
  input  logic               redirect_valid,
  input  logic [31:0]        redirect_pc,
  input  logic               exc_valid,
  input  logic [31:0]        exc_pc,
  output logic [IMEM_AW-1:0] imem_addr,
  input  logic [31:0]        imem_rd,
  output logic [31:0]        pc,
  output logic               if_id_valid,
  output logic [31:0]        if_id_instr,
  output logic [31:0]        if_id_pc,
  output logic [31:0]        if_id_pc4,
  output logic               if_id_fault
);

  logic [31:0] r_pc;
  logic [31:0] w_off;
  logic [31:0] w_pc4;
  logic [31:0] w_pc_next;
  logic        w_fault;
  if_id_t      w_fetch;
  if_id_t      w_q;

  // A PC below TEXT_BASE wraps to a huge offset and fails the range test.
  assign w_off     = r_pc - TEXT_BASE;
  assign w_pc4     = r_pc + 32'd4;
  assign imem_addr = w_off[IMEM_AW+1:2];
  assign w_fault   = (r_pc[1:0] != 2'b00) || (w_off >= TEXT_BYTES);

  // Redirects arriving during a stall are dropped; ID re-asserts them.
  always_comb begin
    w_pc_next = w_pc4;
    if (exc_valid) begin
      w_pc_next = exc_pc;
    end else if (stall) begin
      w_pc_next = r_pc;
    end else if (redirect_valid) begin
      w_pc_next = redirect_pc;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_pc <= TEXT_BASE;
    end else begin
      r_pc <= w_pc_next;
    end
  end

  assign w_fetch = '{valid: 1'b1,
                     instr: w_fault ? NOP : imem_rd,
                     pc:    r_pc,
                     pc4:   w_pc4,
                     fault: w_fault};

  if_id_reg u_if_id_reg (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_bubble (flush | exc_valid),
    .i_hold   (stall),
    .i_load   (w_fetch),
    .o_q      (w_q)
  );

  assign pc          = r_pc;
  assign if_id_valid = w_q.valid;
  assign if_id_instr = w_q.instr;
  assign if_id_pc    = w_q.pc;
  assign if_id_pc4   = w_q.pc4;
  assign if_id_fault = w_q.fault;

endmodule

// File: tb/tb_ifetch.sv
// tb/tb_ifetch.sv - self-checking bench for ifetch
module tb_ifetch;

  localparam logic [31:0] BASE = 32'h0040_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall, flush, redirect_valid, exc_valid;
  logic [31:0] redirect_pc, exc_pc;
  logic [10:0] imem_addr;
  logic [31:0] imem_rd;
  logic [31:0] pc;
  logic        if_id_valid, if_id_fault;
  logic [31:0] if_id_instr, if_id_pc, if_id_pc4;

  logic [31:0] mem [0:2047];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign imem_rd = mem[imem_addr];

  ifetch dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .stall          (stall),
    .flush          (flush),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .exc_valid      (exc_valid),
    .exc_pc         (exc_pc),
    .imem_addr      (imem_addr),
    .imem_rd        (imem_rd),
    .pc             (pc),
    .if_id_valid    (if_id_valid),
    .if_id_instr    (if_id_instr),
    .if_id_pc       (if_id_pc),
    .if_id_pc4      (if_id_pc4),
    .if_id_fault    (if_id_fault)
  );

  typedef struct {
    logic        st, fl, rv;
    logic [31:0] rpc;
    logic        ev;
    logic [31:0] epc;
    logic [31:0] e_pc;
    logic        e_valid;
    logic [31:0] e_instr;
    logic [31:0] e_ifpc;
    logic        e_fault;
  } vec_t;

  vec_t tbl [17];

  // behavioural reference state
  logic [31:0] m_pc, m_instr, m_ipc, m_ipc4;
  logic        m_valid, m_fault;

  function automatic vec_t mk(logic st, logic fl, logic rv, logic [31:0] rpc,
                              logic ev, logic [31:0] epc, logic [31:0] e_pc,
                              logic e_valid, logic [31:0] e_instr,
                              logic [31:0] e_ifpc, logic e_fault);
    vec_t v;
    v.st = st; v.fl = fl; v.rv = rv; v.rpc = rpc; v.ev = ev; v.epc = epc;
    v.e_pc = e_pc; v.e_valid = e_valid; v.e_instr = e_instr;
    v.e_ifpc = e_ifpc; v.e_fault = e_fault;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [31:0] e_pc, input logic e_valid,
                         input logic [31:0] e_instr, input logic [31:0] e_ifpc,
                         input logic [31:0] e_ipc4, input logic e_fault);
    logic [31:0] e_addr;
    e_addr = ((e_pc - BASE) / 4) % 2048;
    chk({tag, " pc"},        pc,                  e_pc);
    chk({tag, " imem_addr"}, {21'd0, imem_addr},  e_addr);
    chk({tag, " valid"},     {31'd0, if_id_valid}, {31'd0, e_valid});
    chk({tag, " instr"},     if_id_instr,         e_instr);
    chk({tag, " if_id_pc"},  if_id_pc,            e_ifpc);
    chk({tag, " if_id_pc4"}, if_id_pc4,           e_ipc4);
    chk({tag, " fault"},     {31'd0, if_id_fault}, {31'd0, e_fault});
  endtask

  task automatic drive(input logic st, input logic fl, input logic rv, input logic [31:0] rpc,
                       input logic ev, input logic [31:0] epc);
    stall = st; flush = fl; redirect_valid = rv; redirect_pc = rpc;
    exc_valid = ev; exc_pc = epc;
  endtask

  // Reference: fetch outcome of a byte address in the text window.
  function automatic logic is_fault(logic [31:0] a);
    return (a % 4 != 0) || (a - BASE >= 32'd8192);
  endfunction

  task automatic model_step;
    logic [31:0] n_pc;
    logic        f;
    f = is_fault(m_pc);
    if (!rst_n)            n_pc = BASE;
    else if (exc_valid)    n_pc = exc_pc;
    else if (stall)        n_pc = m_pc;
    else if (redirect_valid) n_pc = redirect_pc;
    else                   n_pc = m_pc + 4;
    if (!rst_n) begin
      m_valid = 0; m_instr = 0; m_ipc = 0; m_ipc4 = 0; m_fault = 0;
    end else if (flush || exc_valid) begin
      m_valid = 0; m_instr = 0; m_fault = 0; m_ipc = m_pc; m_ipc4 = m_pc + 4;
    end else if (!stall) begin
      m_valid = 1;
      m_instr = f ? 32'h0 : mem[(m_pc - BASE) / 4];
      m_ipc = m_pc; m_ipc4 = m_pc + 4; m_fault = f;
    end
    m_pc = n_pc;
  endtask

  initial begin
    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0, 0);
    for (int k = 0; k < 2048; k++) mem[k] = k + 1;

    // reset state
    @(posedge clk); #1;
    chk_all("reset", BASE, 0, 0, 0, 0, 0);

    tbl[0]  = mk(0,0,0,0,           0,0,            32'h00400004, 1, 1,    32'h00400000, 0);
    tbl[1]  = mk(0,0,0,0,           0,0,            32'h00400008, 1, 2,    32'h00400004, 0);
    tbl[2]  = mk(0,0,1,32'h00400100,0,0,            32'h00400100, 1, 3,    32'h00400008, 0);
    tbl[3]  = mk(1,0,1,32'h00400200,0,0,            32'h00400100, 1, 3,    32'h00400008, 0);
    tbl[4]  = mk(1,0,1,32'h00400200,0,0,            32'h00400100, 1, 3,    32'h00400008, 0);
    tbl[5]  = mk(1,0,1,32'h00400200,0,0,            32'h00400100, 1, 3,    32'h00400008, 0);
    tbl[6]  = mk(0,0,1,32'h00400200,0,0,            32'h00400200, 1, 65,   32'h00400100, 0);
    tbl[7]  = mk(1,0,0,0,           1,32'h00400004, 32'h00400004, 0, 0,    32'h00400200, 0);
    tbl[8]  = mk(0,0,0,0,           0,0,            32'h00400008, 1, 2,    32'h00400004, 0);
    tbl[9]  = mk(0,0,1,32'h00400002,0,0,            32'h00400002, 1, 3,    32'h00400008, 0);
    tbl[10] = mk(0,0,1,32'h00402000,0,0,            32'h00402000, 1, 0,    32'h00400002, 1);
    tbl[11] = mk(0,0,1,32'h003FFFFC,0,0,            32'h003FFFFC, 1, 0,    32'h00402000, 1);
    tbl[12] = mk(0,0,1,32'h00400000,0,0,            32'h00400000, 1, 0,    32'h003FFFFC, 1);
    tbl[13] = mk(0,0,0,0,           0,0,            32'h00400004, 1, 1,    32'h00400000, 0);
    tbl[14] = mk(0,0,1,32'h00401FFC,0,0,            32'h00401FFC, 1, 2,    32'h00400004, 0);
    tbl[15] = mk(0,0,0,0,           0,0,            32'h00402000, 1, 2048, 32'h00401FFC, 0);
    tbl[16] = mk(1,1,0,0,           0,0,            32'h00402000, 0, 0,    32'h00402000, 0);

    rst_n = 1'b1;
    for (int i = 0; i < 17; i++) begin
      drive(tbl[i].st, tbl[i].fl, tbl[i].rv, tbl[i].rpc, tbl[i].ev, tbl[i].epc);
      @(posedge clk); #1;
      chk_all($sformatf("row%0d", i), tbl[i].e_pc, tbl[i].e_valid, tbl[i].e_instr,
              tbl[i].e_ifpc, tbl[i].e_ifpc + 4, tbl[i].e_fault);
    end

    // reset mid-stream wins over every other control
    rst_n = 1'b0;
    drive(1, 1, 1, 32'h00400100, 1, 32'h00400004);
    @(posedge clk); #1;
    chk_all("midreset", BASE, 0, 0, 0, 0, 0);
    rst_n = 1'b1;
    drive(0, 0, 0, 0, 0, 0);
    @(posedge clk); #1;
    chk_all("postreset", 32'h00400004, 1, 1, BASE, BASE + 4, 0);

    // randomized run against the reference model
    for (int k = 0; k < 2048; k++) mem[k] = $urandom;
    m_pc = 0; m_valid = 0; m_instr = 0; m_ipc = 0; m_ipc4 = 0; m_fault = 0;
    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0, 0);
    model_step();
    @(posedge clk); #1;
    chk_all("rnd_reset", m_pc, m_valid, m_instr, m_ipc, m_ipc4, m_fault);
    for (int n = 0; n < 600; n++) begin
      logic [31:0] t;
      rst_n = ($urandom_range(0, 49) != 0);
      case ($urandom_range(0, 9))
        0:       t = BASE + ($urandom_range(0, 8191) | 32'd1);
        1:       t = BASE + 32'd8192 + ($urandom_range(0, 255) << 2);
        2:       t = BASE - (($urandom_range(1, 64)) << 2);
        default: t = BASE + ($urandom_range(0, 2047) << 2);
      endcase
      drive($urandom_range(0, 3) == 0, $urandom_range(0, 9) == 0,
            $urandom_range(0, 3) == 0, t,
            $urandom_range(0, 19) == 0,
            $urandom_range(0, 1) ? 32'h00400004 : BASE + ($urandom_range(0, 2047) << 2));
      model_step();
      @(posedge clk); #1;
      chk_all($sformatf("rnd%0d", n), m_pc, m_valid, m_instr, m_ipc, m_ipc4, m_fault);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
